// File: rtl/depp_host_master_if.sv
// Command and DEPP bus signals of depp_host_master, grouped for connection.
// The master modport is the host block's view; slave is the command source / peripheral side.
interface depp_host_master_if;
   // Command handshake: i_cmd_stb is valid; the command is taken on a rising edge
   // where i_cmd_stb=1 and the FSM sits in IDLE (o_busy=0 and o_done=0).
   logic       i_cmd_stb;
   logic [1:0] i_cmd_op;
   logic [7:0] i_cmd_data;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_rd_data;
   logic       o_timeout;
   logic       o_astb_n;
   logic       o_dstb_n;
   logic       o_write_n;
   logic [7:0] o_depp;
   logic       o_depp_oe;
   logic [7:0] i_depp;
   logic       i_wait;
   logic [2:0] o_dbg_state;

   modport master (
      input  i_cmd_stb, i_cmd_op, i_cmd_data, i_depp, i_wait,
      output o_busy, o_done, o_rd_data, o_timeout, o_astb_n, o_dstb_n,
             o_write_n, o_depp, o_depp_oe, o_dbg_state
   );

   modport slave (
      output i_cmd_stb, i_cmd_op, i_cmd_data, i_depp, i_wait,
      input  o_busy, o_done, o_rd_data, o_timeout, o_astb_n, o_dstb_n,
             o_write_n, o_depp, o_depp_oe, o_dbg_state
   );
endinterface

// File: rtl/depp_host_master.sv
// DEPP (Digilent EPP) host-side master: one address/data read or write per command.
// Optional abort on a stuck peripheral is built when DEPP_TIMEOUT_EN is defined.
module depp_host_master #(
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   depp_host_master_if.master    bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

   state_t     state_q, state_d;
   logic       wait_meta_q, wait_s_q;
   logic [1:0] op_q, op_d;
   logic [7:0] data_q, data_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] set_cnt_q, set_cnt_d;
   logic       in_xfer;

`ifdef DEPP_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         wait_meta_q <= 1'b0;
         wait_s_q    <= 1'b0;
         op_q        <= 2'b00;
         data_q      <= 8'h00;
         rd_data_q   <= 8'h00;
         set_cnt_q   <= 8'h00;
`ifdef DEPP_TIMEOUT_EN
         to_cnt_q    <= 16'h0000;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wait_meta_q <= bus.i_wait;
         wait_s_q    <= wait_meta_q;
         op_q        <= op_d;
         data_q      <= data_d;
         rd_data_q   <= rd_data_d;
         set_cnt_q   <= set_cnt_d;
`ifdef DEPP_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      rd_data_d = rd_data_q;
      set_cnt_d = set_cnt_q;
`ifdef DEPP_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.i_cmd_stb) begin
               op_d      = bus.i_cmd_op;
               data_d    = bus.i_cmd_data;
               set_cnt_d = 8'h00;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // A peripheral still holding wait from a previous cycle keeps us here.
            if (set_cnt_q >= SETUP_LAST && !wait_s_q) begin
               state_d = ST_STROBE;
`ifdef DEPP_TIMEOUT_EN
               to_cnt_d = 16'h0000;
`endif
            end else if (set_cnt_q < SETUP_LAST) begin
               set_cnt_d = set_cnt_q + 8'h01;
            end
         end
         ST_STROBE: begin
            if (wait_s_q) begin
               if (op_q[1]) begin
                  rd_data_d = bus.i_depp;
               end
               state_d = ST_RELEASE;
`ifdef DEPP_TIMEOUT_EN
               to_cnt_d = 16'h0000;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'h0001;
`endif
            end
         end
         ST_RELEASE: begin
            if (!wait_s_q) begin
               state_d = ST_DONE;
`ifdef DEPP_TIMEOUT_EN
            end else if (to_cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'h0001;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode straight from async-reset flops so reset releases the bus at once.
   assign in_xfer = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                    (state_q == ST_RELEASE);

   assign bus.o_astb_n    = !((state_q == ST_STROBE) && !op_q[0]);
   assign bus.o_dstb_n    = !((state_q == ST_STROBE) &&  op_q[0]);
   assign bus.o_write_n   = !(in_xfer && !op_q[1]);
   assign bus.o_depp_oe   = in_xfer && !op_q[1];
   assign bus.o_depp      = data_q;
   assign bus.o_busy      = in_xfer;
   assign bus.o_done      = (state_q == ST_DONE);
   assign bus.o_rd_data   = rd_data_q;
   assign bus.o_dbg_state = state_q;
`ifdef DEPP_TIMEOUT_EN
   assign bus.o_timeout   = timeout_q;
`else
   assign bus.o_timeout   = 1'b0;
`endif

endmodule
